// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// The arbiter FSM state type and the data/address bus width live here.
package mem_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        DONE_IF = 3'd3,
        DONE_DM = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals.
// The master modport is the arbiter's view; slave is the requester/memory view.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              stall_f;
    logic              stall_m;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory access latency counter.
// Held at zero while load is high, then counts up once per cycle and
// parks on MEM_LAT-1, where done is raised.
module mem_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CNT_W-1:0] r_count;

    assign done = (r_count == CNT_W'(MEM_LAT - 1));

    // Count the cycles of an access, restarting whenever no access is running
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
        end else if (!done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by an instruction fetch port and a data port.
// Data requests win by default; define MEM_ARB_FAIRNESS_EN to add a
// starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : g_paramCheck
        $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              w_grantIf;
    logic              w_grantDm;
    logic              w_starveHit;
    logic              w_memBusy;
    logic              w_cntDone;
    logic              r_memWe;
    logic [DATA_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dmRdata;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_latCounter (
        .clk  (clk),
        .rst  (rst),
        .load (~w_memBusy),
        .done (w_cntDone)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] r_starveCnt;

    assign w_starveHit = (r_starveCnt == STARVE_W'(STARVE_MAX));

    // Count back-to-back data grants that left a fetch waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= '0;
        end else if (w_grantDm && bus.if_req) begin
            r_starveCnt <= r_starveCnt + STARVE_W'(1);
        end else if (w_grantDm || w_grantIf) begin
            r_starveCnt <= '0;
        end
    end
`else
    assign w_starveHit = 1'b0;
`endif

    // Grant selection and next-state logic; accesses are never preempted
    always_comb begin
        w_grantDm   = 1'b0;
        w_grantIf   = 1'b0;
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                w_grantDm = bus.dm_req & ~(w_starveHit & bus.if_req);
                w_grantIf = bus.if_req & ~w_grantDm;
                if (w_grantDm) begin
                    w_nextState = BUSY_DM;
                end else if (w_grantIf) begin
                    w_nextState = BUSY_IF;
                end
            end
            BUSY_IF: if (w_cntDone) w_nextState = DONE_IF;
            BUSY_DM: if (w_cntDone) w_nextState = DONE_DM;
            DONE_IF: w_nextState = IDLE;
            DONE_DM: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Latch the granted request so requester changes cannot disturb the access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end else if (w_grantDm) begin
            r_memAddr  <= bus.dm_addr;
            r_memWe    <= bus.dm_we;
            r_memWdata <= bus.dm_wdata;
        end else if (w_grantIf) begin
            r_memAddr  <= bus.if_addr;
            r_memWe    <= 1'b0;
        end
    end

    // Capture read data in the last access cycle; stores leave dm_rdata alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifRdata <= '0;
            r_dmRdata <= '0;
        end else if (w_cntDone && r_state == BUSY_IF) begin
            r_ifRdata <= bus.mem_rdata;
        end else if (w_cntDone && r_state == BUSY_DM && !r_memWe) begin
            r_dmRdata <= bus.mem_rdata;
        end
    end

    assign w_memBusy     = (r_state == BUSY_IF) || (r_state == BUSY_DM);

    assign bus.mem_en    = w_memBusy;
    assign bus.mem_we    = (r_state == BUSY_DM) & r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.if_ready  = (r_state == DONE_IF);
    assign bus.dm_ready  = (r_state == DONE_DM);
    assign bus.if_rdata  = r_ifRdata;
    assign bus.dm_rdata  = r_dmRdata;
    assign bus.stall_f   = bus.if_req & ~bus.if_ready;
    assign bus.stall_m   = bus.dm_req & ~bus.dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Main instance uses MEM_LAT=2 and is tracked by a transaction-timeline model;
// a second instance with MEM_LAT=1 covers the shortest latency.
// Honours MEM_ARB_FAIRNESS_EN when it is defined for the build.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.master)
    );

    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;

    // Model of the arbiter as a timeline of accesses: grant cycle g gives
    // memory activity in g+1..g+LAT and the ready pulse in g+LAT+1.
    bit          modelOn   = 1'b0;
    bit          mActive   = 1'b0;
    bit          mOwnerDm  = 1'b0;
    bit          mWe       = 1'b0;
    int          mGrant    = 0;
    logic [31:0] mWdata    = '0;
    logic [31:0] expMemAddr = '0;
    logic [31:0] expIfRdata = '0;
    logic [31:0] expDmRdata = '0;
    int          starve    = 0;
    bit          prevRst   = 1'b1;
    bit          ifAckSeen = 1'b0;
    bit          dmAckSeen = 1'b0;
    bit          busyNow;
    bit          readyNow;
    bit          idleNow;
    bit          fetchFirst;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, actual, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare the main instance against the timeline model, then advance the model
    always @(negedge clk) begin
        ifAckSeen = (bus.if_ready === 1'b1);
        dmAckSeen = (bus.dm_ready === 1'b1);
        if (modelOn) begin
            busyNow  = mActive && (cyc > mGrant) && (cyc <= mGrant + LAT);
            readyNow = mActive && (cyc == mGrant + LAT + 1);
            idleNow  = !mActive;

            checkOutput("mem_en", bus.mem_en, busyNow);
            checkOutput("mem_we", bus.mem_we, busyNow && mOwnerDm && mWe);
            checkOutput("mem_addr", bus.mem_addr, expMemAddr);
            if (busyNow && mOwnerDm) checkOutput("mem_wdata", bus.mem_wdata, mWdata);
            if (prevRst) checkOutput("mem_wdata_rst", bus.mem_wdata, 32'd0);
            checkOutput("if_ready", bus.if_ready, readyNow && !mOwnerDm);
            checkOutput("dm_ready", bus.dm_ready, readyNow && mOwnerDm);
            checkOutput("stall_f", bus.stall_f, bus.if_req && !(readyNow && !mOwnerDm));
            checkOutput("stall_m", bus.stall_m, bus.dm_req && !(readyNow && mOwnerDm));
            checkOutput("if_rdata", bus.if_rdata, expIfRdata);
            checkOutput("dm_rdata", bus.dm_rdata, expDmRdata);

            prevRst = rst;
            if (rst) begin
                mActive    = 1'b0;
                expMemAddr = '0;
                expIfRdata = '0;
                expDmRdata = '0;
                starve     = 0;
            end else begin
                if (busyNow && cyc == mGrant + LAT) begin
                    if (!mOwnerDm) expIfRdata = bus.mem_rdata;
                    else if (!mWe) expDmRdata = bus.mem_rdata;
                end
                if (readyNow) mActive = 1'b0;
                if (idleNow && (bus.dm_req || bus.if_req)) begin
                    fetchFirst = FAIR && (starve == SMAX);
                    mActive = 1'b1;
                    mGrant  = cyc;
                    if (bus.dm_req && !(fetchFirst && bus.if_req)) begin
                        mOwnerDm   = 1'b1;
                        mWe        = bus.dm_we;
                        mWdata     = bus.dm_wdata;
                        expMemAddr = bus.dm_addr;
                        starve     = bus.if_req ? starve + 1 : 0;
                    end else begin
                        mOwnerDm   = 1'b0;
                        mWe        = 1'b0;
                        expMemAddr = bus.if_addr;
                        starve     = 0;
                    end
                end
            end
        end
    end

    // One cycle of random requester/memory behaviour; requesters hold until acknowledged
    task automatic applyStimulus(input int ifRate, input int dmRate);
        if (!bus.if_req || ifAckSeen) begin
            bus.if_req  = ($urandom_range(0, 99) < ifRate);
            bus.if_addr = $urandom;
        end
        if (!bus.dm_req || dmAckSeen) begin
            bus.dm_req   = ($urandom_range(0, 99) < dmRate);
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
        end
        bus.mem_rdata = $urandom;
        rst = ($urandom_range(0, 149) == 0);
    endtask

    // Issue a request on one or both ports and hold each until its ready pulse
    task automatic issueAndWait(input bit doIf, input logic [31:0] ia, input bit doDm,
                                input bit we, input logic [31:0] da, input logic [31:0] dw,
                                input logic [31:0] rd);
        bit ifOpen = doIf;
        bit dmOpen = doDm;
        bus.if_req    = doIf;
        bus.if_addr   = ia;
        bus.dm_req    = doDm;
        bus.dm_we     = we;
        bus.dm_addr   = da;
        bus.dm_wdata  = dw;
        bus.mem_rdata = rd;
        for (int k = 0; k < 30 && (ifOpen || dmOpen); k++) begin
            @(posedge clk); #1;
            if (ifOpen && ifAckSeen) begin
                ifOpen     = 1'b0;
                bus.if_req = 1'b0;
            end
            if (dmOpen && dmAckSeen) begin
                dmOpen     = 1'b0;
                bus.dm_req = 1'b0;
            end
        end
        checkOutput("handshake_timeout", {30'd0, ifOpen, dmOpen}, 32'd0);
    endtask

    task automatic idleCycles(input int n);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int ifReadyCount;

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus1.mem_rdata = '0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        modelOn = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_en", bus.mem_en, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
        checkOutput("rst_dm_ready", bus.dm_ready, 1'b0);
        @(posedge clk); #1;
        rst  = 1'b0;
        rst1 = 1'b0;

        $display("[TB] directed fetch");
        issueAndWait(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
        checkOutput("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);

        $display("[TB] directed load then store");
        issueAndWait(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h55);
        checkOutput("load_rdata", bus.dm_rdata, 32'h55);
        issueAndWait(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234, 32'h77777777);
        checkOutput("store_keeps_rdata", bus.dm_rdata, 32'h55);

        $display("[TB] simultaneous requests");
        issueAndWait(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5);

        $display("[TB] reset during fetch");
        idleCycles(3);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_mem_en", bus.mem_en, 1'b0);
        checkOutput("abort_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("abort_if_ready", bus.if_ready, 1'b0);
        checkOutput("abort_if_rdata", bus.if_rdata, 32'd0);
        issueAndWait(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h600DF00D);
        checkOutput("after_abort_rdata", bus.if_rdata, 32'h600DF00D);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(50, 40);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idleCycles(LAT + 3);

        $display("[TB] continuous data with pending fetch");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h400;
        ifReadyCount = 0;
        for (int i = 0; i < 40; i++) begin
            bus.mem_rdata = $urandom;
            @(negedge clk);
            if (bus.if_ready === 1'b1) ifReadyCount++;
            @(posedge clk); #1;
        end
        checkOutput("starve_fetch_served", ifReadyCount != 0, FAIR);
        idleCycles(LAT + 3);

        $display("[TB] MEM_LAT=1 load");
        bus1.dm_req    = 1'b1;
        bus1.dm_we     = 1'b0;
        bus1.dm_addr   = 32'h40;
        bus1.mem_rdata = 32'h11112222;
        @(negedge clk);
        checkOutput("lat1_c0_mem_en", bus1.mem_en, 1'b0);
        checkOutput("lat1_c0_stall_m", bus1.stall_m, 1'b1);
        @(posedge clk); #1;
        bus1.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("lat1_c1_mem_en", bus1.mem_en, 1'b1);
        checkOutput("lat1_c1_mem_addr", bus1.mem_addr, 32'h40);
        checkOutput("lat1_c1_dm_ready", bus1.dm_ready, 1'b0);
        @(posedge clk); #1;
        bus1.mem_rdata = 32'h11112222;
        @(negedge clk);
        checkOutput("lat1_c2_mem_en", bus1.mem_en, 1'b0);
        checkOutput("lat1_c2_dm_ready", bus1.dm_ready, 1'b1);
        checkOutput("lat1_c2_dm_rdata", bus1.dm_rdata, 32'hCAFEF00D);
        checkOutput("lat1_c2_stall_m", bus1.stall_m, 1'b0);
        @(posedge clk); #1;
        bus1.dm_req = 1'b0;
        @(negedge clk);
        checkOutput("lat1_c3_dm_ready", bus1.dm_ready, 1'b0);

        @(posedge clk); #1;
        modelOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory access latency in cycles (legal range 1..15).
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits (used only with MEM_ARB_FAIRNESS_EN).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  registered fetch data
- if_ready  out  1  one-cycle fetch completion pulse
- dm_req  in  1  load/store request; held with dm_we, dm_addr, dm_wdata until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  registered load data
- dm_ready  out  1  one-cycle data completion pulse
- stall_f  out  1  if_req & ~if_ready, combinational
- stall_m  out  1  dm_req & ~dm_ready, combinational
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  32  latched access address
- mem_wdata  out  32  latched store data
- mem_rdata  in  32  memory read data, valid in the last access cycle

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, DONE_IF and DONE_DM.
REQ-005 IDLE: if dm_req, SHALL go to BUSY_DM; else if if_req, SHALL go to BUSY_IF; else SHALL stay in IDLE. Data has priority (older instruction).
REQ-006 On leaving IDLE for a grant, SHALL latch the granted address into mem_addr; for data, SHALL also latch dm_we into mem_we and dm_wdata into mem_wdata; for fetch, mem_we SHALL be 0.
REQ-007 BUSY_x: SHALL hold mem_en=1 and the latched signals for exactly MEM_LAT cycles.
- Counter runs 0..MEM_LAT-1.
- At MEM_LAT-1 SHALL go to DONE_x.
- On a load or fetch, SHALL capture mem_rdata into the owner's rdata register at that edge.
REQ-008 DONE_x: SHALL assert x_ready=1 for one cycle with mem_en=0 and mem_we=0, then go to IDLE unconditionally.
REQ-009 Latency from the cycle a request is first seen in IDLE to its ready pulse SHALL be MEM_LAT+1 cycles.
REQ-010 On a store, dm_rdata SHALL keep its previous value.
REQ-011 Requests arriving while not in IDLE SHALL wait; the current access is never preempted.
REQ-012 Changes to requester inputs during BUSY SHALL NOT affect the latched memory signals.

Reset
REQ-013 On rst=1 at a clock edge, SHALL go to IDLE and clear the counter, the starvation counter and all registered outputs to 0: if_rdata, dm_rdata, if_ready, dm_ready, mem_en, mem_we, mem_addr, mem_wdata.
REQ-014 Reset during BUSY or DONE SHALL abort the access: mem_en=0 in the next cycle and no ready pulse for the aborted access.

Configuration
REQ-015 With MEM_ARB_FAIRNESS_EN defined, SHALL add a starvation counter:
- Increments on each data grant made while if_req=1.
- Clears on a fetch grant, or on a data grant with if_req=0.
- When it equals STARVE_MAX and both requests are pending in IDLE, SHALL grant fetch.
REQ-016 Without MEM_ARB_FAIRNESS_EN, SHALL use strict data priority and SHALL NOT contain the starvation counter.

Structure
REQ-017 Package mem_arb_pkg SHALL hold the FSM state typedef arb_state_t and the constant DATA_W=32.
REQ-018 The latency counter SHALL be sub-module mem_lat_counter, with ports clk, rst, load, done and a width sized for MEM_LAT.

Verification (MEM_LAT=2 unless stated; cycle 0 = request first seen in IDLE)
REQ-019 Fetch only, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en=1 and mem_addr=0x10 in cycles 1-2; if_ready=1 in cycle 3; if_rdata=0xDEADBEEF; stall_f=1 in cycles 0-2.
REQ-020 if_req and dm_req both high in cycle 0 -> data access in cycles 1-2 and dm_ready in cycle 3; fetch access in cycles 5-6 and if_ready in cycle 7.
REQ-021 Store, dm_addr=0x20, dm_wdata=0x1234, with dm_rdata previously 0x55 -> mem_we=1 and mem_wdata=0x1234 in cycles 1-2; dm_ready in cycle 3; dm_rdata stays 0x55.
REQ-022 rst=1 in cycle 1 of a fetch -> cycle 2 shows mem_en=0 and all outputs 0; no if_ready; a new request is accepted from IDLE afterwards.
REQ-023 dm_req held continuously and if_req high, STARVE_MAX=4 -> with MEM_ARB_FAIRNESS_EN, the 5th grant is fetch; without it, if_ready stays 0 for 40 cycles.
REQ-024 MEM_LAT=1, single load -> mem_en=1 in cycle 1 only; dm_ready=1 in cycle 2.
